// File: rtl/lane_pkg.sv
// rtl/lane_pkg.sv - shared lane constants, types and bit-reverse helper
package lane_pkg;
  localparam int WIDTH = 13;
  localparam int LANES = 7;
  localparam int SELW  = 3;
  localparam int CNTW  = 16;

  typedef logic [SELW-1:0] lane_idx_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  // Lane words travel with bit k carrying original bit WIDTH-1-k.
  function automatic logic [WIDTH-1:0] bitrev13(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    for (int k = 0; k < WIDTH; k++) begin
      r[k] = d[WIDTH-1-k];
    end
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter7.sv
// rtl/rr_arbiter7.sv - 7-way round-robin arbiter, scan starts at ptr
module rr_arbiter7
  import lane_pkg::*;
(
  input  logic [LANES-1:0] req,
  input  lane_idx_t        ptr,
  input  logic             en,
  output logic [LANES-1:0] gnt,
  output lane_idx_t        gnt_idx,
  output logic             any
);
  always_comb begin
    lane_idx_t start;
    lane_idx_t cand;
    logic      found;
    // An out-of-range pointer (upset) restarts the scan at lane 0.
    start   = (ptr >= lane_idx_t'(LANES)) ? '0 : ptr;
    found   = 1'b0;
    cand    = '0;
    gnt_idx = '0;
    for (int off = 0; off < LANES; off++) begin
      if (int'(start) + off >= LANES) begin
        cand = lane_idx_t'(int'(start) + off - LANES);
      end else begin
        cand = lane_idx_t'(int'(start) + off);
      end
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    any = |req;
    gnt = '0;
    if (en && any) begin
      gnt[gnt_idx] = 1'b1;
    end
  end
endmodule

// File: rtl/mux7_13_collector.sv
// rtl/mux7_13_collector.sv - collects 7 bit-reversed lanes onto one 13-bit stream
module mux7_13_collector
  import lane_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES-1:0]       in_valid,
  output logic [LANES-1:0]       in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [SELW-1:0]        out_sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CNTW-1:0]        xfer_cnt
);
  out_state_t       state;
  lane_idx_t        rr_ptr;
  lane_idx_t        gnt_idx;
  logic             any;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] sel_word;

  assign out_valid  = (state == FULL);
  assign can_accept = !out_valid || out_ready;
  assign accept     = can_accept && any && rst_n;

  // Grant is masked while reset is held so no lane sees a handshake.
  rr_arbiter7 u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .en      (can_accept && rst_n),
    .gnt     (in_ready),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < LANES; i++) begin
      if (gnt_idx == lane_idx_t'(i)) begin
        sel_word = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_data <= '0;
      out_sel  <= '0;
      rr_ptr   <= '0;
      xfer_cnt <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state <= FULL;
          end
        end
        FULL: begin
          if (out_ready && !accept) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
      if (accept) begin
        out_data <= bitrev13(sel_word);
        out_sel  <= gnt_idx;
        rr_ptr   <= (gnt_idx == lane_idx_t'(LANES-1)) ? '0 : gnt_idx + 3'd1;
        xfer_cnt <= xfer_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mux7_13_collector.sv
// tb/tb_mux7_13_collector.sv - scoreboard bench for mux7_13_collector
module tb_mux7_13_collector;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [90:0] in_data;
  logic [6:0]  in_valid;
  logic [6:0]  in_ready;
  logic [12:0] out_data;
  logic [2:0]  out_sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] xfer_cnt;

  logic [12:0] dat [7];
  logic        clear_on_take;
  int          total = 0;
  int          bad   = 0;

  int          m_ptr;
  logic        m_valid;
  logic [15:0] m_cnt;
  logic [15:0] q [$];

  always #5 clk = ~clk;

  always_comb begin
    in_data = '0;
    for (int i = 0; i < 7; i++) in_data[i*13 +: 13] = dat[i];
  end

  mux7_13_collector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] rev(input logic [12:0] d);
    logic [12:0] r;
    for (int k = 0; k < 13; k++) r[k] = d[12-k];
    return r;
  endfunction

  function automatic int pick(input logic [6:0] r, input int p);
    for (int off = 0; off < 7; off++) begin
      if (r[(p + off) % 7]) return (p + off) % 7;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_cnt   = '0;
    q.delete();
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    int          g;
    logic [15:0] e;
    logic [6:0]  exp_rdy;
    #1;
    g = (!m_valid || out_ready) ? pick(in_valid, m_ptr) : -1;
    exp_rdy = (g >= 0) ? (7'b1 << g) : 7'b0;
    check("in_ready", {25'd0, in_ready}, {25'd0, exp_rdy});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid && out_ready) begin
      if (q.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("out_sel", {29'd0, out_sel}, {29'd0, e[15:13]});
        check("out_data", {19'd0, out_data}, {19'd0, e[12:0]});
      end
    end
    if (g >= 0) begin
      q.push_back({3'(g), rev(dat[g])});
    end
    @(posedge clk);
    #1;
    if (g >= 0) begin
      m_ptr   = (g == 6) ? 0 : g + 1;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 16'd1;
      dat[g]  = 13'($urandom);
      if (clear_on_take) in_valid[g] = 1'b0;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    check("xfer_cnt", {16'd0, xfer_cnt}, {16'd0, m_cnt});
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [6:0] v);
    rst_n    = 1'b0;
    in_valid = v;
    model_reset();
    #1;
    check("rst_in_ready", {25'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
    check("rst_out_data", {19'd0, out_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [12:0] held_d;
    logic [2:0]  held_s;
    for (int i = 0; i < 7; i++) dat[i] = 13'($urandom);
    out_ready     = 1'b1;
    clear_on_take = 1'b1;
    @(negedge clk);

    // 1: reset with every lane requesting, lane 0 first after release
    do_reset(7'h7F);
    cycle();
    check("t1_first_sel", {29'd0, out_sel}, 32'd0);
    in_valid = '0;
    cycle();

    // 2: bit restore on lane 3
    do_reset(7'h00);
    dat[3]   = 13'h0001;
    in_valid = 7'b0001000;
    cycle();
    check("t2_out_data", {19'd0, out_data}, 32'h1000);
    check("t2_out_sel", {29'd0, out_sel}, 32'd3);
    check("t2_xfer_cnt", {16'd0, xfer_cnt}, 32'd1);
    cycle();

    // 3: round robin over all lanes at full throughput
    do_reset(7'h7F);
    clear_on_take = 1'b0;
    for (int i = 0; i < 14; i++) begin
      cycle();
      check("t3_seq", {29'd0, out_sel}, 32'(i % 7));
    end
    in_valid = '0;
    cycle();

    // 4: backpressure with lanes 2 and 5 valid
    do_reset(7'b0100100);
    cycle();
    held_d    = out_data;
    held_s    = out_sel;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t4_hold_data", {19'd0, out_data}, {19'd0, held_d});
      check("t4_hold_sel", {29'd0, out_sel}, 32'd2);
    end
    out_ready = 1'b1;
    cycle();
    check("t4_next_sel", {29'd0, out_sel}, 32'd5);
    check("t4_still_valid", {31'd0, out_valid}, 32'd1);
    in_valid = '0;
    cycle();
    cycle();

    // 5: counter wrap after 65536 accepts, pointer wraps 6 -> 0 throughout
    do_reset(7'h7F);
    for (int i = 0; i < 65536; i++) cycle();
    check("t5_wrap", {16'd0, xfer_cnt}, 32'd0);
    in_valid = '0;
    cycle();

    // 6: reset while a word is held under backpressure
    do_reset(7'b0000010);
    clear_on_take = 1'b1;
    out_ready     = 1'b0;
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", {31'd0, out_valid}, 32'd0);
    check("t6_async_ready", {25'd0, in_ready}, 32'd0);
    @(negedge clk);
    model_reset();
    in_valid  = '0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    check("t6_no_word", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
